reg_file_16x20: RTL

//   16-entry x 20-bit register file for the 20-bit datapath. It is the stage directly

---
 rtl/reg_file_pkg.sv | 13 +
 rtl/mux16to1.sv | 10 +
 rtl/reg_file_16x20.sv | 94 +++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared widths and FSM encoding for the 16x20 register file
package reg_file_pkg;
  localparam int DATA_W   = 20;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;
endpackage

// File: rtl/mux16to1.sv
// rtl/mux16to1.sv - 16:1 word select used for each register file read port
module mux16to1
  import reg_file_pkg::*;
(
  input  logic [DATA_W-1:0] din [NUM_REGS],
  input  logic [ADDR_W-1:0] sel,
  output logic [DATA_W-1:0] dout
);
  assign dout = din[sel];
endmodule

// File: rtl/reg_file_16x20.sv
// rtl/reg_file_16x20.sv - 16x20 register file, 1W/2R registered reads, R0 = 0, 16-cycle clear
module reg_file_16x20
  import reg_file_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid,
  input  logic              clr_start,
  output logic              busy
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] mux_a, mux_b;
  logic              wr_ok;

  mux16to1 u_mux_a (.din(regs_q), .sel(raddr_a), .dout(mux_a));
  mux16to1 u_mux_b (.din(regs_q), .sel(raddr_b), .dout(mux_b));

  // Entry 0 is only ever loaded with zero (writes to it are dropped), so it reads as zero.
  assign wr_ok = we && (state_q == IDLE) && (waddr != '0);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    regs_d    = regs_q;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    rvalid_d  = re;

    if (wr_ok) regs_d[waddr] = wdata;

    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        regs_d[clr_cnt_q] = '0;
        clr_cnt_d         = clr_cnt_q + 4'd1;
        if (clr_cnt_q == LAST_IDX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Write-first forwarding; a clear in progress forces zeros on both ports.
    if (re) begin
      if (state_q == CLEAR) begin
        rdata_a_d = '0;
        rdata_b_d = '0;
      end else begin
        rdata_a_d = (wr_ok && waddr == raddr_a) ? wdata : mux_a;
        rdata_b_d = (wr_ok && waddr == raddr_b) ? wdata : mux_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      rvalid_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      rvalid_q  <= rvalid_d;
      regs_q    <= regs_d;
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;
  assign rvalid  = rvalid_q;
  assign busy    = (state_q == CLEAR);
endmodule
